// File: rtl/miriscv_mem_pkg.sv
// Shared constants and the response-state type for the data-memory responder.
package miriscv_mem_pkg;

    localparam int          DATA_W          = 32;
    localparam int          BE_W            = 4;
    localparam int          DEPTH_WORDS_DEF = 1024;
    localparam logic [31:0] BASE_ADDR_DEF   = 32'h0000_0000;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        RESP = 1'b1
    } rsp_state_e;

endpackage

// File: rtl/miriscv_bram_be.sv
// Single-port byte-enable RAM, one 8-bit array per lane, synchronous read.
module miriscv_bram_be
    import miriscv_mem_pkg::*;
#(
    parameter int DEPTH_WORDS = DEPTH_WORDS_DEF
) (
    input  logic                           clk,
    input  logic                           en,
    input  logic                           we,
    input  logic [BE_W-1:0]                be,
    input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
    input  logic [DATA_W-1:0]              wdata,
    output logic [DATA_W-1:0]              rdata
);

    // Read port only updates on reads, so rdata holds across writes and idle cycles
    for (genvar i = 0; i < BE_W; i++) begin : g_lane
        logic [7:0] mem [DEPTH_WORDS];
        logic [7:0] rd_p1;

        always_ff @(posedge clk) begin
            if (en) begin
                if (we) begin
                    if (be[i]) begin
                        mem[addr] <= wdata[8*i +: 8];
                    end
                end else begin
                    rd_p1 <= mem[addr];
                end
            end
        end

        assign rdata[8*i +: 8] = rd_p1;
    end

endmodule

// File: rtl/miriscv_data_mem.sv
// LSU-facing data-memory responder: address decode, sub-word alignment,
// response FSM, sticky error flag and saturating access counters.
module miriscv_data_mem
    import miriscv_mem_pkg::*;
#(
    parameter int          DEPTH_WORDS = DEPTH_WORDS_DEF,
    parameter logic [31:0] BASE_ADDR   = BASE_ADDR_DEF
) (
    input  logic              clk,
    input  logic              rst_n_i,
    input  logic              data_req_i,
    input  logic              data_we_i,
    input  logic [BE_W-1:0]   data_be_i,
    input  logic [31:0]       data_addr_i,
    input  logic [DATA_W-1:0] data_wdata_i,
    output logic [DATA_W-1:0] data_rdata_o,
    output logic              data_err_o,
    output logic [31:0]       rd_cnt_o,
    output logic [31:0]       wr_cnt_o
);

    localparam int          AW   = $clog2(DEPTH_WORDS);
    localparam logic [31:0] SPAN = 32'(DEPTH_WORDS) << 2;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    logic [31:0]       off;
    logic              in_range;
    logic              be_any;
    logic              acc;
    logic              rd_hit;
    logic              rd_oor;
    logic              wr_hit;
    logic              err_hit;
    logic [DATA_W-1:0] ram_rdata;
    logic [DATA_W-1:0] ram_shift;

    // Stage p0: decode of the request presented this cycle
    assign off      = data_addr_i - BASE_ADDR;
    assign in_range = off < SPAN;
    assign be_any   = |data_be_i;
    assign acc      = data_req_i & rst_n_i;
    assign rd_hit   = acc & ~data_we_i & in_range;
    assign rd_oor   = acc & ~data_we_i & ~in_range;
    assign wr_hit   = acc & data_we_i & in_range & be_any;
    assign err_hit  = acc & (~in_range | (data_we_i & ~be_any));

    miriscv_bram_be #(
        .DEPTH_WORDS(DEPTH_WORDS)
    ) u_ram (
        .clk  (clk),
        .en   (rd_hit | wr_hit),
        .we   (data_we_i),
        .be   (data_be_i),
        .addr (off[AW+1:2]),
        .wdata(data_wdata_i),
        .rdata(ram_rdata)
    );

    // Stage p1: registered read word, lane offset, response state
    rsp_state_e        state_p1;
    logic [1:0]        shift_p1;
    logic [DATA_W-1:0] hold_p1;
    logic              err_p1;
    logic [31:0]       rd_cnt_q;
    logic [31:0]       wr_cnt_q;

    always_ff @(posedge clk) begin
        if (rd_hit) begin
            shift_p1 <= data_addr_i[1:0];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n_i) begin
            state_p1 <= IDLE;
            hold_p1  <= '0;
            err_p1   <= 1'b0;
            rd_cnt_q <= '0;
            wr_cnt_q <= '0;
        end else begin
            state_p1 <= rd_hit ? RESP : IDLE;
            hold_p1  <= rd_oor ? '0 : data_rdata_o;
            if (err_hit) begin
                err_p1 <= 1'b1;
            end
            if (rd_hit) begin
                rd_cnt_q <= sat_inc(rd_cnt_q);
            end
            if (wr_hit) begin
                wr_cnt_q <= sat_inc(wr_cnt_q);
            end
        end
    end

    // Fresh RAM data is only meaningful in RESP; otherwise the last response is replayed
    assign ram_shift    = ram_rdata >> {shift_p1, 3'b000};
    assign data_rdata_o = (state_p1 == RESP) ? ram_shift : hold_p1;
    assign data_err_o   = err_p1;
    assign rd_cnt_o     = rd_cnt_q;
    assign wr_cnt_o     = wr_cnt_q;

endmodule

// File: tb/tb_miriscv_data_mem.sv
// Directed bench for miriscv_data_mem: reset, sub-word reads, lane writes,
// error cases and counter saturation.
module tb_miriscv_data_mem;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [3:0]  be;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    logic [31:0] rd_cnt;
    logic [31:0] wr_cnt;

    int passed = 0;
    int total  = 0;

    always #5 clk = ~clk;

    miriscv_data_mem dut (
        .clk         (clk),
        .rst_n_i     (rst_n),
        .data_req_i  (req),
        .data_we_i   (we),
        .data_be_i   (be),
        .data_addr_i (addr),
        .data_wdata_i(wdata),
        .data_rdata_o(rdata),
        .data_err_o  (err),
        .rd_cnt_o    (rd_cnt),
        .wr_cnt_o    (wr_cnt)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic step(input logic r, input logic w, input logic [3:0] b,
                        input logic [31:0] a, input logic [31:0] d, input logic rn);
        rst_n = rn;
        req   = r;
        we    = w;
        be    = b;
        addr  = a;
        wdata = d;
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        step(0, 0, 4'h0, 32'h0, 32'h0, 0);
        step(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("rst_rdata", rdata, 32'h0);
        chk("rst_err", {31'b0, err}, 32'h0);
        chk("rst_rd_cnt", rd_cnt, 32'h0);
        chk("rst_wr_cnt", wr_cnt, 32'h0);

        // Seed word 0, then try to overwrite it while in reset
        step(1, 1, 4'hF, 32'h0, 32'h1122_3344, 1);
        step(1, 1, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        step(1, 1, 4'hF, 32'h0, 32'hDEAD_BEEF, 0);
        chk("rst_wr_rdata", rdata, 32'h0);
        chk("rst_wr_cnt_clr", wr_cnt, 32'h0);
        step(1, 0, 4'h0, 32'h0, 32'h0, 1);
        chk("rst_write_ignored", rdata, 32'h1122_3344);
        chk("rd_cnt_1", rd_cnt, 32'h1);

        step(1, 1, 4'hF, 32'h10, 32'h8765_4321, 1);
        chk("write_holds_rdata", rdata, 32'h1122_3344);
        chk("wr_cnt_1", wr_cnt, 32'h1);
        step(1, 0, 4'h0, 32'h11, 32'h0, 1);
        chk("byte_11_full", rdata, 32'h0087_6543);
        chk("byte_11_low", {24'h0, rdata[7:0]}, 32'h43);
        req  = 1'b1;
        we   = 1'b0;
        addr = 32'h13;
        #1;
        chk("byte_13_not_yet", rdata, 32'h0087_6543);
        step(1, 0, 4'h0, 32'h13, 32'h0, 1);
        chk("byte_13", rdata, 32'h87);
        step(1, 0, 4'h0, 32'h12, 32'h0, 1);
        chk("half_12", rdata, 32'h8765);

        step(1, 1, 4'b0100, 32'h10, 32'hAAAA_AAAA, 1);
        step(1, 0, 4'h0, 32'h10, 32'h0, 1);
        chk("lane2_write", rdata, 32'h87AA_4321);

        step(1, 1, 4'hF, 32'h20, 32'h1234_5678, 1);
        step(1, 1, 4'hF, 32'h20, 32'h1234_5678, 1);
        chk("wr_cnt_held", wr_cnt, 32'h4);
        step(1, 0, 4'h0, 32'h20, 32'h0, 1);
        chk("raw_b2b", rdata, 32'h1234_5678);
        chk("rd_cnt_6", rd_cnt, 32'h6);
        chk("no_err_yet", {31'b0, err}, 32'h0);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1);
        step(0, 0, 4'h0, 32'h0, 32'h0, 1);
        chk("idle_hold", rdata, 32'h1234_5678);

        step(1, 0, 4'h0, 32'h1000, 32'h0, 1);
        chk("oor_rdata", rdata, 32'h0);
        chk("oor_err", {31'b0, err}, 32'h1);
        chk("oor_rd_cnt", rd_cnt, 32'h6);
        chk("oor_wr_cnt", wr_cnt, 32'h4);

        step(0, 0, 4'h0, 32'h0, 32'h0, 0);
        chk("err_cleared", {31'b0, err}, 32'h0);
        step(1, 1, 4'hF, 32'h30, 32'hCAFE_BABE, 1);
        step(1, 1, 4'h0, 32'h31, 32'hFFFF_FFFF, 1);
        chk("be0_err", {31'b0, err}, 32'h1);
        chk("be0_wr_cnt", wr_cnt, 32'h1);
        step(1, 0, 4'h0, 32'h30, 32'h0, 1);
        chk("be0_ram_kept", rdata, 32'hCAFE_BABE);

        force dut.rd_cnt_q = 32'hFFFF_FFFE;
        #1;
        release dut.rd_cnt_q;
        #1;
        chk("sat_forced", rd_cnt, 32'hFFFF_FFFE);
        step(1, 0, 4'h0, 32'h30, 32'h0, 1);
        chk("sat_1", rd_cnt, 32'hFFFF_FFFF);
        step(1, 0, 4'h0, 32'h30, 32'h0, 1);
        step(1, 0, 4'h0, 32'h30, 32'h0, 1);
        chk("sat_3", rd_cnt, 32'hFFFF_FFFF);

        step(1, 0, 4'h0, 32'h10, 32'h0, 0);
        chk("rst_mid_read", rdata, 32'h0);
        chk("rst_mid_rd_cnt", rd_cnt, 32'h0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/miriscv_data_mem.md
# miriscv_data_mem

Data-memory responder for the core's load/store memory protocol: services `data_req`/`data_we`/`data_be`/`data_addr`/`data_wdata` from the LSU and returns `data_rdata`. It sits between the LSU and the on-chip data RAM. It provides byte-enable writes, one-cycle registered reads with right-aligned sub-word data, range/alignment error flagging, and saturating access counters for bring-up.

## Interface
- `DEPTH_WORDS`, default 1024: RAM depth in 32-bit words. Must be a power of two, ≥ 4.
- `BASE_ADDR`, default 32'h0000_0000: byte address of word 0. Must be `DEPTH_WORDS*4`-aligned.
- `clk` input 1: the single clock. All state changes on its rising edge.
- `rst_n_i` input 1: reset, synchronous, active-low.
- `data_req_i` input 1: access request this cycle.
- `data_we_i` input 1: 1 = write, 0 = read. Valid only with `data_req_i`.
- `data_be_i` input 4: byte-lane enables for writes. Lane n = bits [8n+7:8n].
- `data_addr_i` input 32: byte address.
- `data_wdata_i` input 32: write data, already lane-replicated by the initiator.
- `data_rdata_o` output 32: read data, right-aligned.
- `data_err_o` output 1: sticky error flag.
- `rd_cnt_o` output 32: count of accepted in-range reads, saturating.
- `wr_cnt_o` output 32: count of accepted in-range writes with `be≠0`, saturating.

## Operation
- Offset is `off = data_addr_i - BASE_ADDR`. The access is in range iff `off < DEPTH_WORDS*4`. Word index is `off[log2(DEPTH_WORDS)+1:2]`.
- Every cycle with `data_req_i=1` is an independent access. The initiator holds req for two cycles per access (request cycle plus its one stall-release cycle). Repeated writes are idempotent, so no de-duplication is done.
- **Write** (`req & we`, in range, `be≠0`):
  - Each byte lane with `be[n]=1` takes `data_wdata_i[8n+7:8n]` at the clock edge. Other lanes are unchanged.
  - `data_rdata_o` holds its previous value.
- **Read** (`req & ~we`, in range):
  - The word is read synchronously.
  - `data_rdata_o = word >> (8*data_addr_i[1:0])`, zero-filled at the top. The initiator sign/zero-extends from bits [7:0]/[15:0]. A halfword at offset 2 therefore lands in [15:0].
- **Out of range**, any direction: RAM untouched, `data_err_o←1`, counters unchanged. For a read, `data_rdata_o←0`.
- **Write with `be=0`** (the initiator's misaligned encoding): RAM untouched, `data_err_o←1`, `wr_cnt_o` unchanged.
- **Counters**: each increments by 1 per qualifying cycle, so one two-cycle access counts 2. They saturate at 32'hFFFF_FFFF.
- **Idle** (`req=0`): `data_rdata_o` holds its value. No state change.

## Timing
- Read latency is 1 cycle. Request at edge k yields `data_rdata_o` valid after edge k+1 and stable until the next read or reset.
- Write is committed at the edge ending the request cycle. A read of the same word in the following cycle returns the new data.
- Read-after-write is not a hazard. Simultaneous read and write cannot occur (single port).
- **Reset** (`rst_n_i=0` sampled at an edge):
  - `data_rdata_o=0`, `data_err_o=0`, `rd_cnt_o=0`, `wr_cnt_o=0`.
  - RAM contents are not cleared.
  - A request during a reset cycle is ignored entirely, including writes.
  - Reset mid-access discards the pending read result.
- Response FSM, tracking only output validity:
  - `IDLE` → `RESP` on an in-range read.
  - `RESP` → `RESP` on another read, → `IDLE` otherwise.
  - `data_rdata_o` updates only on entry or re-entry to `RESP`.
  - Reset → `IDLE`.
- `data_err_o` clears only on reset.

## Structure
- Package `miriscv_mem_pkg` holds `DATA_W=32`, `BE_W=4`, default `DEPTH_WORDS` and `BASE_ADDR`, and the `rsp_state_e` enum (`IDLE`, `RESP`).
- Sub-module `miriscv_bram_be`: single-port byte-enable RAM with synchronous read. It contains 4 byte-lane arrays, is inferable as block RAM, and takes ports `clk`, `en`, `we`, `be[3:0]`, `addr`, `wdata`, `rdata`.
- The top level holds the address decode, alignment shifter, FSM, error flag and counters.

## Test plan
- **Reset values**: after reset, all outputs are 0. A write of 32'hDEAD_BEEF issued during reset is not stored: a later read of address 0 returns the prior contents.
- **Word then sub-word**: write word 32'h8765_4321 at 0x10 with `be=4'b1111`.
  - Byte reads at 0x11/0x13 return 32'h43 / 32'h87.
  - Halfword read at 0x12 returns 32'h8765.
  - Each read is valid exactly 1 cycle after req.
- **Byte-lane write**: write 0x10 with `be=4'b0100`, `wdata=32'hAAAA_AAAA`. A word read of 0x10 returns 32'h87AA_4321.
- **Back-to-back**: write 0x20 = 32'h1234_5678, then read 0x20 in the next cycle → 32'h1234_5678. A two-cycle-held write increments `wr_cnt_o` by 2.
- **Errors**:
  - A read at `BASE_ADDR+DEPTH_WORDS*4` gives `data_rdata_o=0`, `data_err_o=1` and counters unchanged.
  - A write with `be=0` at 0x31 sets the error flag and leaves the RAM unchanged.
- **Saturation**: force `rd_cnt_o` to 32'hFFFF_FFFE, perform 3 reads → 32'hFFFF_FFFF and it holds there.
